// File: rtl/scan_line_window.sv
`default_nettype none
// ============================================================================
// Module      : scan_line_window
// Description : Line scanner for the Connect-6 threat evaluator. Walks every
//               line of one board direction, buffers each line from the
//               board RAM, slides a K-cell window along it and, for every
//               single-colour window, emits a weight update for each empty
//               cell of that window to the weight accumulator.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, all state on rising edge
//   reset      in   asynchronous active-high reset, returns block to idle
//   start      in   one-cycle scan request, honoured only when idle
//   dir        in   0 horiz, 1 vert, 2 diag (x-y const), 3 anti (x+y const)
//   colour     in   colour played by this side (0 black, 1 white)
//   abort      in   synchronous abandon, idle next cycle without done
//   rd_en      out  board read strobe, one per cell
//   rd_x/rd_y  out  board read address
//   rd_data    in   cell value one cycle after rd_en (00 blk, 01 wht,
//                   10 empty, 11 blocked)
//   wr_valid   out  weight update valid
//   wr_ready   in   accumulator accepts on wr_valid && wr_ready
//   wr_x/wr_y  out  target empty cell
//   wr_weight  out  weight to add
//   busy       out  scan in progress
//   done       out  one-cycle pulse when the scan completes
//   win_found  out  some window held K stones of one colour this scan
//   win_colour out  colour of the first winning window
// ============================================================================
module scan_line_window #(
    parameter int BOARD_N = 19,
    parameter int K       = 6,
    parameter int CW      = 5,
    parameter int WW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    dir,
    input  logic          colour,
    input  logic          abort,
    output logic          rd_en,
    output logic [CW-1:0] rd_x,
    output logic [CW-1:0] rd_y,
    input  logic [1:0]    rd_data,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [CW-1:0] wr_x,
    output logic [CW-1:0] wr_y,
    output logic [WW-1:0] wr_weight,
    output logic          busy,
    output logic          done,
    output logic          win_found,
    output logic          win_colour
);

    // One extra bit over the coordinate width: line index reaches 2N-2 and
    // line length reaches N, either of which can overflow CW bits.
    localparam int LW = CW + 1;
    localparam int IW = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;

    localparam logic [LW-1:0] c_N      = LW'(BOARD_N);
    localparam logic [LW-1:0] c_NM1    = LW'(BOARD_N - 1);
    localparam logic [LW-1:0] c_2NM1   = LW'(2 * BOARD_N - 1);
    localparam logic [LW-1:0] c_K      = LW'(K);
    localparam logic [LW-1:0] c_KM1    = LW'(K - 1);
    localparam logic [LW-1:0] c_KM2    = LW'(K - 2);
    localparam logic [WW-1:0] c_THREAT = WW'(2 * K - 1);
    localparam logic [1:0]    c_EMPTY  = 2'b10;
    localparam logic [1:0]    c_BLOCK  = 2'b11;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LINE_SETUP = 3'd1;
    localparam logic [2:0] S_FETCH      = 3'd2;
    localparam logic [2:0] S_WIN_COUNT  = 3'd3;
    localparam logic [2:0] S_WIN_EMIT   = 3'd4;
    localparam logic [2:0] S_NEXT_WIN   = 3'd5;
    localparam logic [2:0] S_NEXT_LINE  = 3'd6;
    localparam logic [2:0] S_DONE       = 3'd7;

    logic [2:0]    r_state;
    logic [1:0]    r_dir;
    logic          r_colour;
    logic [LW-1:0] r_line;      // current line index
    logic [LW-1:0] r_len;       // length of current line
    logic [CW-1:0] r_x0;        // first cell of current line
    logic [CW-1:0] r_y0;
    logic [LW-1:0] r_idx;       // fetch position within the line
    logic [LW-1:0] r_s;         // window start within the line
    logic [LW-1:0] r_j;         // offset within the window being emitted
    logic [1:0]    r_buf [0:BOARD_N-1];

    logic          r_rdEn;
    logic [CW-1:0] r_rdX;
    logic [CW-1:0] r_rdY;
    logic          r_wrValid;
    logic [CW-1:0] r_wrX;
    logic [CW-1:0] r_wrY;
    logic [WW-1:0] r_weight;
    logic          r_busy;
    logic          r_done;
    logic          r_winFound;
    logic          r_winColour;

    logic [CW-1:0] w_setupX0;
    logic [CW-1:0] w_setupY0;
    logic [LW-1:0] w_setupLen;
    logic [LW-1:0] w_lastLine;
    logic [LW-1:0] w_own;
    logic [LW-1:0] w_opp;
    logic          w_blk;
    logic [LW-1:0] w_winPos;
    logic [WW-1:0] w_weight;
    logic [LW-1:0] w_nextPos;
    logic          w_nextEmpty;

    // Map a position along the current line to board coordinates. Lines are
    // always walked in ascending x; vertical lines walk ascending y, and the
    // anti-diagonal therefore walks descending y.
    function automatic logic [2*CW-1:0] cellCoord(input logic [LW-1:0] pos);
        logic [LW-1:0] x;
        logic [LW-1:0] y;
        x = {1'b0, r_x0};
        y = {1'b0, r_y0};
        case (r_dir)
            2'd0: x = x + pos;
            2'd1: y = y + pos;
            2'd2: begin
                x = x + pos;
                y = y + pos;
            end
            default: begin
                x = x + pos;
                y = y - pos;
            end
        endcase
        return {CW'(x), CW'(y)};
    endfunction

    // Start cell and length of line r_line. Diagonal lines are numbered so
    // that line l holds cells with x-y = l-(N-1); anti-diagonal line l holds
    // cells with x+y = l. Both have length l+1 below the main diagonal and
    // 2N-1-l above it.
    always_comb begin
        w_setupX0  = '0;
        w_setupY0  = '0;
        w_setupLen = c_N;
        w_lastLine = r_dir[1] ? (c_2NM1 - LW'(1)) : c_NM1;
        case (r_dir)
            2'd0: w_setupY0 = CW'(r_line);
            2'd1: w_setupX0 = CW'(r_line);
            2'd2: begin
                if (r_line >= c_NM1) begin
                    w_setupX0  = CW'(r_line - c_NM1);
                    w_setupLen = c_2NM1 - r_line;
                end else begin
                    w_setupY0  = CW'(c_NM1 - r_line);
                    w_setupLen = r_line + LW'(1);
                end
            end
            default: begin
                if (r_line <= c_NM1) begin
                    w_setupY0  = CW'(r_line);
                    w_setupLen = r_line + LW'(1);
                end else begin
                    w_setupX0  = CW'(r_line - c_NM1);
                    w_setupY0  = CW'(c_NM1);
                    w_setupLen = c_2NM1 - r_line;
                end
            end
        endcase
    end

    // Stone census of the window starting at r_s.
    always_comb begin
        w_own    = '0;
        w_opp    = '0;
        w_blk    = 1'b0;
        w_winPos = '0;
        for (int j = 0; j < K; j++) begin
            w_winPos = r_s + LW'(j);
            if (r_buf[IW'(w_winPos)] == c_BLOCK) begin
                w_blk = 1'b1;
            end else if (r_buf[IW'(w_winPos)] == {1'b0, r_colour}) begin
                w_own = w_own + LW'(1);
            end else if (r_buf[IW'(w_winPos)] == {1'b0, ~r_colour}) begin
                w_opp = w_opp + LW'(1);
            end
        end
    end

    // Opponent-only windows one or two stones short of a win are threats and
    // get the top weight; own-only windows rank above every lesser threat.
    always_comb begin
        w_weight = WW'(c_KM1 + w_own);
        if (w_opp != '0) begin
            w_weight = (w_opp >= c_KM2) ? c_THREAT : WW'(w_opp);
        end
    end

    // Look-ahead to the next cell to present on the write port, so a fresh
    // cell can be offered in the same edge that retires the previous one.
    always_comb begin
        w_nextPos = r_s + r_j + LW'(1);
        if (r_state == S_WIN_COUNT) begin
            w_nextPos = r_s;
        end
        w_nextEmpty = (r_buf[IW'(w_nextPos)] == c_EMPTY);
    end

    // Line buffer capture: rd_data is valid in the cycle after the strobe.
    always_ff @(posedge clk) begin
        if (r_state == S_FETCH && !r_rdEn) begin
            r_buf[IW'(r_idx)] <= rd_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_dir       <= '0;
            r_colour    <= 1'b0;
            r_line      <= '0;
            r_len       <= '0;
            r_x0        <= '0;
            r_y0        <= '0;
            r_idx       <= '0;
            r_s         <= '0;
            r_j         <= '0;
            r_rdEn      <= 1'b0;
            r_rdX       <= '0;
            r_rdY       <= '0;
            r_wrValid   <= 1'b0;
            r_wrX       <= '0;
            r_wrY       <= '0;
            r_weight    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_winFound  <= 1'b0;
            r_winColour <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                // Abandon without done; any pending handshake is withdrawn.
                r_state   <= S_IDLE;
                r_rdEn    <= 1'b0;
                r_wrValid <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_dir       <= dir;
                            r_colour    <= colour;
                            r_line      <= '0;
                            r_busy      <= 1'b1;
                            r_winFound  <= 1'b0;
                            r_winColour <= 1'b0;
                            r_state     <= S_LINE_SETUP;
                        end
                    end

                    S_LINE_SETUP: begin
                        r_x0  <= w_setupX0;
                        r_y0  <= w_setupY0;
                        r_len <= w_setupLen;
                        if (w_setupLen < c_K) begin
                            // Too short to hold a window: no reads at all.
                            r_state <= S_NEXT_LINE;
                        end else begin
                            r_idx   <= '0;
                            r_rdEn  <= 1'b1;
                            r_rdX   <= w_setupX0;
                            r_rdY   <= w_setupY0;
                            r_state <= S_FETCH;
                        end
                    end

                    S_FETCH: begin
                        // Alternate address cycle (rd_en high) and capture
                        // cycle (rd_en low, data lands in the buffer).
                        if (r_rdEn) begin
                            r_rdEn <= 1'b0;
                        end else if (r_idx == r_len - LW'(1)) begin
                            r_s     <= '0;
                            r_state <= S_WIN_COUNT;
                        end else begin
                            r_idx          <= r_idx + LW'(1);
                            r_rdEn         <= 1'b1;
                            {r_rdX, r_rdY} <= cellCoord(r_idx + LW'(1));
                        end
                    end

                    S_WIN_COUNT: begin
                        if (w_blk || (w_own != '0 && w_opp != '0) ||
                            (w_own == '0 && w_opp == '0)) begin
                            r_state <= S_NEXT_WIN;
                        end else if (w_own == c_K || w_opp == c_K) begin
                            if (!r_winFound) begin
                                r_winFound  <= 1'b1;
                                r_winColour <= (w_own == c_K) ? r_colour : ~r_colour;
                            end
                            r_state <= S_NEXT_WIN;
                        end else begin
                            r_weight       <= w_weight;
                            r_j            <= '0;
                            r_wrValid      <= w_nextEmpty;
                            {r_wrX, r_wrY} <= cellCoord(w_nextPos);
                            r_state        <= S_WIN_EMIT;
                        end
                    end

                    S_WIN_EMIT: begin
                        // Advance on a completed handshake or on a non-empty
                        // cell; otherwise hold the payload for the consumer.
                        if (!(r_wrValid && !wr_ready)) begin
                            if (r_j == c_KM1) begin
                                r_wrValid <= 1'b0;
                                r_state   <= S_NEXT_WIN;
                            end else begin
                                r_j            <= r_j + LW'(1);
                                r_wrValid      <= w_nextEmpty;
                                {r_wrX, r_wrY} <= cellCoord(w_nextPos);
                            end
                        end
                    end

                    S_NEXT_WIN: begin
                        if (r_s == r_len - c_K) begin
                            r_state <= S_NEXT_LINE;
                        end else begin
                            r_s     <= r_s + LW'(1);
                            r_state <= S_WIN_COUNT;
                        end
                    end

                    S_NEXT_LINE: begin
                        if (r_line == w_lastLine) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_line  <= r_line + LW'(1);
                            r_state <= S_LINE_SETUP;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_en      = r_rdEn;
    assign rd_x       = r_rdX;
    assign rd_y       = r_rdY;
    assign wr_valid   = r_wrValid;
    assign wr_x       = r_wrX;
    assign wr_y       = r_wrY;
    assign wr_weight  = r_weight;
    assign busy       = r_busy;
    assign done       = r_done;
    assign win_found  = r_winFound;
    assign win_colour = r_winColour;

endmodule
`default_nettype wire
